// File: rtl/load_seq_pkg.sv
// Shared encodings for the load sequencer and the masked register file write port:
// FSM states, load size codes and half-register mask codes.
package load_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_LO   = 2'b01;
    localparam logic [1:0] SZ_HI   = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_FULL = 2'b11;

    // Place a byte in the low half, zero- or sign-extended into the high half.
    function automatic logic [15:0] byte_ext(input logic [7:0] b, input logic sext);
        return sext ? {{8{b[7]}}, b} : {8'h00, b};
    endfunction

endpackage

// File: rtl/load_sequencer.sv
// Byte/word load sequencer feeding the 16-bit masked register file.
// Optional feature macro: LOAD_SIGN_EXT_EN (adds reqSigned for sign-extended low-byte loads).
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int REG_W  = 16,
    parameter int DST_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [1:0]        reqSize,
    input  logic [DST_W-1:0]  reqDst,
`ifdef LOAD_SIGN_EXT_EN
    input  logic              reqSigned,
`endif
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [7:0]        memData,
    output logic              regEn,
    output logic [DST_W-1:0]  regSel,
    output logic [REG_W-1:0]  regData,
    output logic [1:0]        regInMask,
    output logic [1:0]        regOutMask,
    output logic              busy
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DST_W-1:0]  dst_q;
    logic [7:0]        lo_q;
    logic [REG_W-1:0]  data_q;
    logic              accept;
    logic              sext_lo;

    assign accept = reqValid && (state == IDLE);

`ifdef LOAD_SIGN_EXT_EN
    logic sgn_q;

    always_ff @(posedge clk) begin
        if (rst)
            sgn_q <= 1'b0;
        else if (accept)
            sgn_q <= reqSigned;
    end

    assign sext_lo = sgn_q && (size_q == SZ_LO);
`else
    assign sext_lo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (reqValid && reqSize != SZ_NONE) state_nx = RD_LO;
            RD_LO:   if (memAck) state_nx = (size_q == SZ_WORD) ? RD_HI : WB;
            RD_HI:   if (memAck) state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The write word is built as the last byte arrives, so regData is a plain
    // register during WB and naturally holds afterwards; data_q[15:8] is the high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            size_q <= SZ_NONE;
            dst_q  <= '0;
            lo_q   <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= reqAddr;
                size_q <= reqSize;
                dst_q  <= reqDst;
            end
            if (state == RD_LO && memAck) begin
                lo_q <= memData;
                if (size_q != SZ_WORD)
                    data_q <= byte_ext(memData, sext_lo);
            end
            if (state == RD_HI && memAck)
                data_q <= {memData, lo_q};
        end
    end

    always_comb begin
        reqReady   = (state == IDLE);
        busy       = (state != IDLE);
        memReq     = (state == RD_LO) || (state == RD_HI);
        memAddr    = (state == RD_HI) ? addr_q + ADDR_W'(1) : addr_q;
        regEn      = (state == WB);
        regSel     = dst_q;
        regData    = data_q;
        regInMask  = MASK_NONE;
        regOutMask = MASK_NONE;
        if (state == WB) begin
            if (size_q == SZ_WORD || sext_lo) begin
                regInMask  = MASK_FULL;
                regOutMask = MASK_FULL;
            end else begin
                regInMask  = MASK_LO;
                regOutMask = size_q;
            end
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Randomized self-checking bench for load_sequencer against a transaction-level model.
module tb_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [15:0] reqAddr;
    logic [1:0]  reqSize;
    logic [3:0]  reqDst;
`ifdef LOAD_SIGN_EXT_EN
    logic        reqSigned;
`endif
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [7:0]  memData;
    logic        regEn;
    logic [3:0]  regSel;
    logic [15:0] regData;
    logic [1:0]  regInMask;
    logic [1:0]  regOutMask;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [15:0] last_data = 16'h0;

    load_sequencer #(.ADDR_W(16), .REG_W(16), .DST_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqAddr(reqAddr),
        .reqSize(reqSize),
        .reqDst(reqDst),
`ifdef LOAD_SIGN_EXT_EN
        .reqSigned(reqSigned),
`endif
        .memReq(memReq),
        .memAddr(memAddr),
        .memAck(memAck),
        .memData(memData),
        .regEn(regEn),
        .regSel(regSel),
        .regData(regData),
        .regInMask(regInMask),
        .regOutMask(regOutMask),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Transaction-level expectation of the single write beat.
    function automatic void model(input logic [1:0] sz, input bit sg, input logic [7:0] b0,
                                  input logic [7:0] b1, output logic [15:0] d,
                                  output logic [1:0] im, output logic [1:0] om);
        case (sz)
            2'd3: begin d = 16'(b1) * 16'd256 + 16'(b0); im = 2'd3; om = 2'd3; end
            2'd2: begin d = 16'(b0); im = 2'd1; om = 2'd2; end
            default: begin
                if (sg) begin
                    d  = (b0 >= 8'd128) ? 16'(b0) + 16'hFF00 : 16'(b0);
                    im = 2'd3; om = 2'd3;
                end else begin
                    d = 16'(b0); im = 2'd1; om = 2'd1;
                end
            end
        endcase
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, reqReady, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_memreq"}, memReq, 0);
        chk({tag, "_regen"}, regEn, 0);
        chk({tag, "_inmask"}, regInMask, 0);
        chk({tag, "_outmask"}, regOutMask, 0);
        chk({tag, "_data"}, regData, last_data);
    endtask

    // Issue one load and play the memory side; starts and ends at a negedge.
    task automatic run_load(input logic [15:0] a, input logic [1:0] sz, input logic [3:0] d,
                            input bit sg, input logic [7:0] b0, input logic [7:0] b1,
                            input int w0, input int w1, input bit hold);
        int n;
        int nrd;
        bit sg_eff;
        logic [15:0] ae;
        logic [15:0] ed;
        logic [1:0]  eim, eom;
        n = 0;
        while (!reqReady && n < 20) begin step(); n++; end
        chk("pre_ready", reqReady, 1);
        reqValid = 1'b1; reqAddr = a; reqSize = sz; reqDst = d;
`ifdef LOAD_SIGN_EXT_EN
        reqSigned = sg;
        sg_eff = sg;
`else
        sg_eff = 1'b0;
`endif
        step();
        if (sz == 2'd0) begin
            for (int i = 0; i < 3; i++) begin
                check_idle("sz0");
                step();
            end
            reqValid = 1'b0;
            return;
        end
        if (hold) begin
            reqValid = 1'b1; reqAddr = 16'($urandom); reqSize = 2'($urandom); reqDst = 4'($urandom);
        end else begin
            reqValid = 1'b0;
        end
        chk("busy_ready", reqReady, 0);
        nrd = (sz == 2'd3) ? 2 : 1;
        for (int r = 0; r < nrd; r++) begin
            ae = a + 16'(r);
            for (int k = 0; k <= ((r == 0) ? w0 : w1); k++) begin
                chk("memreq", memReq, 1);
                chk("memaddr", memAddr, ae);
                chk("rd_regen", regEn, 0);
                if (k == ((r == 0) ? w0 : w1)) begin
                    memAck = 1'b1; memData = (r == 0) ? b0 : b1;
                end else begin
                    memAck = 1'b0; memData = 8'($urandom);
                end
                step();
            end
        end
        memAck = 1'($urandom); memData = 8'($urandom);
        reqValid = 1'b0;
        model(sz, sg_eff, b0, b1, ed, eim, eom);
        chk("wb_regen", regEn, 1);
        chk("wb_sel", regSel, d);
        chk("wb_data", regData, ed);
        chk("wb_inmask", regInMask, eim);
        chk("wb_outmask", regOutMask, eom);
        chk("wb_memreq", memReq, 0);
        chk("wb_ready", reqReady, 0);
        last_data = ed;
        step();
        memAck = 1'b0;
        check_idle("post");
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b1; reqAddr = 16'h5555; reqSize = 2'd3; reqDst = 4'hF;
`ifdef LOAD_SIGN_EXT_EN
        reqSigned = 1'b0;
`endif
        memAck = 1'b1; memData = 8'hEE;
        repeat (3) step();
        check_idle("rst");
        chk("rst_addr", memAddr, 0);
        chk("rst_sel", regSel, 0);
        rst = 1'b0; reqValid = 1'b0; memAck = 1'b0;
        step();
        check_idle("rst_rel");

        run_load(16'h1234, 2'd3, 4'd3, 1'b0, 8'hCD, 8'hAB, 0, 0, 1'b0);
        run_load(16'h0040, 2'd2, 4'd5, 1'b0, 8'h7F, 8'h00, 3, 0, 1'b0);
        run_load(16'hFFFF, 2'd3, 4'd9, 1'b0, 8'h34, 8'h12, 1, 2, 1'b0);
        run_load(16'h0100, 2'd0, 4'd1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
        run_load(16'h0200, 2'd1, 4'd2, 1'b0, 8'h80, 8'h00, 0, 0, 1'b1);
        run_load(16'h0201, 2'd1, 4'd4, 1'b0, 8'h11, 8'h00, 0, 0, 1'b1);
`ifdef LOAD_SIGN_EXT_EN
        run_load(16'h0300, 2'd1, 4'd6, 1'b1, 8'h80, 8'h00, 0, 0, 1'b0);
        run_load(16'h0300, 2'd2, 4'd6, 1'b1, 8'h80, 8'h00, 0, 0, 1'b0);
`endif

        // Reset lands in RD_HI together with memAck: no write may follow.
        reqValid = 1'b1; reqAddr = 16'h2000; reqSize = 2'd3; reqDst = 4'd7;
        step();
        reqValid = 1'b0; memAck = 1'b1; memData = 8'h11;
        step();
        chk("mid_addr", memAddr, 16'h2001);
        memData = 8'h22; rst = 1'b1;
        step();
        rst = 1'b0; memAck = 1'b0;
        last_data = 16'h0;
        chk("mid_addr0", memAddr, 0);
        chk("mid_sel", regSel, 0);
        for (int i = 0; i < 3; i++) begin
            check_idle("mid");
            step();
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            run_load(16'($urandom), sz, 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     (sz != 2'd0) && ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
